// File: rtl/sat_error_unit_pkg.sv
// sat_error_unit_pkg: shared width, saturation limits and FSM state encoding for sat_error_unit.
package sat_error_unit_pkg;
    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIFF = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;
endpackage

// File: rtl/sat_error_unit_sub.sv
// sat_sub: combinational signed saturating a - b with a clamp indicator.
module sat_sub
    import sat_error_unit_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             sat
);
    logic [WIDTH-1:0] raw;
    logic             ovf;
    logic             unf;

    always_comb begin
        raw = a - b;
        ovf = !a[WIDTH-1] && b[WIDTH-1] && raw[WIDTH-1];
        unf = a[WIDTH-1] && !b[WIDTH-1] && !raw[WIDTH-1];
        y   = ovf ? SAT_MAX : unf ? SAT_MIN : raw;
        sat = ovf || unf;
    end
endmodule

// File: rtl/sat_error_unit.sv
// sat_error_unit: sequential saturating error / integral / difference front end
// for the servo loop, one sample per four cycles over valid/ready handshakes.
module sat_error_unit
    import sat_error_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ref,
    input  logic [WIDTH-1:0] Meas,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] D,
    output logic [2:0]       sat_flags,
    output logic             out_valid,
    input  logic             out_ready
);
    state_t           state, next;
    logic [WIDTH-1:0] ref_q, meas_q, e_prev;
    logic [WIDTH-1:0] e_val, d_val, i_raw, i_val;
    logic             e_sat, d_sat, i_ovf, i_unf;

    sat_sub u_sub_e (.a(ref_q), .b(meas_q), .y(e_val), .sat(e_sat));
    sat_sub u_sub_d (.a(E),     .b(e_prev), .y(d_val), .sat(d_sat));

    always_comb begin
        i_raw = I + E;
        i_ovf = !I[WIDTH-1] && !E[WIDTH-1] && i_raw[WIDTH-1];
        i_unf = I[WIDTH-1] && E[WIDTH-1] && !i_raw[WIDTH-1];
        i_val = i_ovf ? SAT_MAX : i_unf ? SAT_MIN : i_raw;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_comb begin
        next = state;
        case (state)
            IDLE: next = in_valid ? DIFF : IDLE;
            DIFF: next = ACC;
            ACC:  next = OUT;
            OUT:  next = out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ref_q     <= '0;
            meas_q    <= '0;
            E         <= '0;
            I         <= '0;
            D         <= '0;
            e_prev    <= '0;
            sat_flags <= '0;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    if (clr) begin
                        I      <= '0;
                        e_prev <= '0;
                    end
                    if (in_valid) begin
                        ref_q  <= Ref;
                        meas_q <= Meas;
                    end
                end
                DIFF: begin
                    E            <= e_val;
                    sat_flags[0] <= e_sat;
                end
                ACC: begin
                    I            <= i_val;
                    D            <= d_val;
                    sat_flags[1] <= i_ovf || i_unf;
                    sat_flags[2] <= d_sat;
                end
                OUT: if (out_ready) e_prev <= E;
            endcase
        end
    end
endmodule

// File: tb/tb_sat_error_unit.sv
// tb_sat_error_unit: scoreboard bench for sat_error_unit with an independent wide-integer model.
module tb_sat_error_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [15:0] Ref = 0, Meas = 0;
    logic        in_valid = 0, clr = 0, out_ready = 1;
    logic        in_ready, out_valid;
    logic [15:0] E, I, D;
    logic [2:0]  sat_flags;

    typedef struct {
        logic [15:0] e;
        logic [15:0] i;
        logic [15:0] d;
        logic [2:0]  f;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mi = 0;
    int   mep = 0;

    sat_error_unit dut (
        .clk(clk), .rst_n(rst_n), .Ref(Ref), .Meas(Meas), .in_valid(in_valid),
        .in_ready(in_ready), .clr(clr), .E(E), .I(I), .D(D),
        .sat_flags(sat_flags), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic expect_outputs(input string tag, input exp_t x);
        check({tag, "_E"}, {16'd0, E}, {16'd0, x.e});
        check({tag, "_I"}, {16'd0, I}, {16'd0, x.i});
        check({tag, "_D"}, {16'd0, D}, {16'd0, x.d});
        check({tag, "_flags"}, {29'd0, sat_flags}, {29'd0, x.f});
    endtask

    task automatic push_model(input logic [15:0] r, input logic [15:0] m, input logic c);
        exp_t x;
        int   re, ri, rd, e;
        if (c) begin
            mi  = 0;
            mep = 0;
        end
        re  = sx(r) - sx(m);
        e   = clampi(re);
        ri  = mi + e;
        rd  = e - mep;
        mi  = clampi(ri);
        x.e = 16'(e);
        x.i = 16'(mi);
        x.d = 16'(clampi(rd));
        x.f = {rd != clampi(rd), ri != mi, re != e};
        sb.push_back(x);
    endtask

    task automatic sample(input string tag, input logic [15:0] r, input logic [15:0] m,
                          input logic c, input int stall);
        exp_t x;
        exp_t held;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        Ref = r; Meas = m; in_valid = 1; clr = c; out_ready = (stall == 0);
        push_model(r, m, c);
        @(negedge clk);
        in_valid = 0; clr = 0;
        @(negedge clk);
        check({tag, "_ov_k1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_ov_k2"}, {31'd0, out_valid}, 32'd1);
        x = sb.pop_front();
        if (stall > 0) begin
            held = x;
            for (int j = 0; j < stall; j++) begin
                in_valid = 1; clr = 1; Ref = 16'($urandom); Meas = 16'($urandom);
                @(negedge clk);
                check({tag, "_stall_ov"}, {31'd0, out_valid}, 32'd1);
                check({tag, "_stall_ir"}, {31'd0, in_ready}, 32'd0);
                expect_outputs({tag, "_stall"}, held);
            end
            in_valid = 0; clr = 0; out_ready = 1;
        end
        expect_outputs(tag, x);
        mep = sx(x.e);
        @(negedge clk);
        check({tag, "_done_ir"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_done_ov"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        exp_t z;
        z = '{e: 16'd0, i: 16'd0, d: 16'd0, f: 3'd0};
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        expect_outputs("reset", z);
        check("reset_ov", {31'd0, out_valid}, 32'd0);
        check("reset_ir", {31'd0, in_ready}, 32'd1);

        sample("s100_30", 16'd100, 16'd30, 0, 0);
        sample("s10_50", 16'd10, 16'd50, 0, 0);
        sample("emax", 16'h7FFF, 16'h8000, 0, 0);
        sample("emin", 16'h8000, 16'h0001, 0, 0);
        sample("iclr", 16'h7FFF, 16'h0000, 1, 0);
        sample("isat", 16'h7FFF, 16'h0000, 0, 0);
        sample("idec", 16'h0000, 16'h0001, 0, 0);
        sample("stall", 16'd5, 16'd3, 0, 5);
        sample("clrval", 16'hFFF9, 16'd2, 1, 0);

        // reset while the sample sits in ACC must discard it and zero everything
        @(negedge clk);
        Ref = 16'd1000; Meas = 16'd1; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        expect_outputs("rst_acc", z);
        check("rst_acc_ov", {31'd0, out_valid}, 32'd0);
        mi = 0; mep = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_rel_ir", {31'd0, in_ready}, 32'd1);
        sample("after_rst", 16'd20, 16'd5, 0, 0);

        for (int k = 0; k < 8; k++)
            sample("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1) & (k == 3)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
